// File: rtl/prog_loader.sv
// prog_loader: streams little-endian host bytes into instruction memory, then enables the CPU.
// Define PROG_LOADER_VERIFY_EN to add a read-back checksum pass before the CPU is released.
module prog_loader #(
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [IDX_W:0]   num_words,
    input  logic             halt,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // state   | meaning
    // IDLE    | waiting for start; CPU held off
    // COLLECT | assembling four host bytes into one word
    // WRITE   | single-cycle write strobe for the assembled word
    // VRD     | read strobe for word_idx (verify build only)
    // VCHK    | fold read data into rsum (verify build only)
    // RUN     | program loaded, CPU enabled until halt
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        VRD     = 3'd3,
        VCHK    = 3'd4,
        RUN     = 3'd5
    } state_t;

    localparam logic [IDX_W:0] CAPACITY = {1'b1, {IDX_W{1'b0}}};

    state_t           state;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_cnt;
    logic [23:0]      word_buf;
    logic [31:0]      sum;
    logic [IDX_W:0]   nw_reg;
    logic [IDX_W:0]   idx_next;
    logic             more_words;
    logic             nw_ok;

    assign idx_next   = {1'b0, word_idx} + {{IDX_W{1'b0}}, 1'b1};
    assign more_words = idx_next < nw_reg;
    assign nw_ok      = (num_words != '0) && (num_words <= CAPACITY);

`ifdef PROG_LOADER_VERIFY_EN
    logic [31:0] rsum;
    logic [31:0] rsum_next;

    assign rsum_next = rsum + rdata_ext;
`else
    logic unused_inputs;

    assign unused_inputs = ^{rdata_ext, sum};
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            sum        <= '0;
            nw_reg     <= '0;
            in_ready   <= 1'b0;
            addr_ext   <= '0;
            wen_ext    <= 1'b0;
            ren_ext    <= 1'b0;
            wdata_ext  <= '0;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
            rsum       <= '0;
`endif
        end else begin
            // Strobes and buses default low; each state re-asserts what it owns.
            wen_ext   <= 1'b0;
            ren_ext   <= 1'b0;
            done      <= 1'b0;
            addr_ext  <= '0;
            wdata_ext <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (nw_ok) begin
                            state    <= COLLECT;
                            word_idx <= '0;
                            byte_cnt <= '0;
                            sum      <= '0;
                            nw_reg   <= num_words;
                            error    <= 1'b0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (in_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= in_byte;
                            2'd1: word_buf[15:8]  <= in_byte;
                            2'd2: word_buf[23:16] <= in_byte;
                            default: begin
                                // Fourth byte goes straight onto the write bus.
                                state     <= WRITE;
                                in_ready  <= 1'b0;
                                wen_ext   <= 1'b1;
                                addr_ext  <= 64'({word_idx, 2'b00});
                                wdata_ext <= {in_byte, word_buf};
                            end
                        endcase
                    end
                end

                WRITE: begin
                    sum <= sum + wdata_ext;
                    if (more_words) begin
                        state    <= COLLECT;
                        word_idx <= idx_next[IDX_W-1:0];
                        in_ready <= 1'b1;
                    end else begin
`ifdef PROG_LOADER_VERIFY_EN
                        state    <= VRD;
                        word_idx <= '0;
                        rsum     <= '0;
                        ren_ext  <= 1'b1;
`else
                        state      <= RUN;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        cpu_enable <= 1'b1;
`endif
                    end
                end

`ifdef PROG_LOADER_VERIFY_EN
                VRD: begin
                    state <= VCHK;
                end

                VCHK: begin
                    if (more_words) begin
                        state    <= VRD;
                        word_idx <= idx_next[IDX_W-1:0];
                        rsum     <= rsum_next;
                        ren_ext  <= 1'b1;
                        addr_ext <= 64'({idx_next[IDX_W-1:0], 2'b00});
                    end else if (rsum_next == sum) begin
                        state      <= RUN;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        cpu_enable <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
`endif

                RUN: begin
                    if (halt) begin
                        state      <= IDLE;
                        cpu_enable <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    in_ready   <= 1'b0;
                    busy       <= 1'b0;
                    cpu_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table of load requests, byte-stream driver,
// write scoreboard, memory model and hand-written reset/halt/verify sequences.
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int IDX_W = 9;
    localparam int CAP   = 1 << IDX_W;
`ifdef PROG_LOADER_VERIFY_EN
    localparam int VERIFY = 1;
`else
    localparam int VERIFY = 0;
`endif

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W:0]   num_words = '0;
    logic             halt = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_byte = '0;
    logic             in_ready;
    logic [63:0]      addr_ext;
    logic             wen_ext;
    logic             ren_ext;
    logic [31:0]      wdata_ext;
    logic [31:0]      rdata_ext = '0;
    logic             cpu_enable;
    logic             busy;
    logic             done;
    logic             error;

    prog_loader #(.IDX_W(IDX_W)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .num_words(num_words), .halt(halt),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready), .addr_ext(addr_ext),
        .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 64'(act), 64'(exp));
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s bound expired", name);
    endtask

    // Host byte stream
    logic [7:0] tx_q[$];
    bit bubble = 1'b0;
    bit tog = 1'b0;

    always @(negedge clk) begin
        tog = ~tog;
        if (tx_q.size() > 0 && !(bubble && tog)) begin
            in_valid = 1'b1;
            in_byte  = tx_q[0];
        end else begin
            in_valid = 1'b0;
            in_byte  = '0;
        end
    end

    always @(posedge clk)
        if (arst_n && in_valid && in_ready && tx_q.size() > 0)
            void'(tx_q.pop_front());

    // Instruction memory model
    logic [31:0] mem [0:CAP-1];
    bit corrupt1 = 1'b0;

    always @(posedge clk) begin
        if (wen_ext) mem[addr_ext[IDX_W+1:2]] <= wdata_ext;
        if (ren_ext)
            rdata_ext <= mem[addr_ext[IDX_W+1:2]] ^
                         ((corrupt1 && addr_ext[IDX_W+1:2] == 1) ? 32'h0000_0100 : 32'h0);
    end

    // Write scoreboard and per-cycle output rules
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    int wen_cnt = 0;
    int ren_cnt = 0;
    int done_cnt = 0;
    bit cpu_seen = 1'b0;

    always @(negedge clk) begin
        if (arst_n) begin
            check1("wen_ren_exclusive", wen_ext & ren_ext, 1'b0);
            if (!busy) check1("in_ready_outside_collect", in_ready, 1'b0);
            if (!wen_ext) check("wdata_idle_zero", 64'(wdata_ext), 64'h0);
            if (!wen_ext && !ren_ext) check("addr_idle_zero", addr_ext, 64'h0);
            if (wen_ext) begin
                wen_cnt++;
                check1("in_ready_during_write", in_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=0x%0h data=0x%0h", addr_ext, wdata_ext);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("write_addr", addr_ext, w.addr);
                    check("write_data", 64'(wdata_ext), 64'(w.data));
                end
            end
            if (ren_ext) ren_cnt++;
            if (done) done_cnt++;
            if (cpu_enable) cpu_seen = 1'b1;
        end
    end

    logic [31:0] words_q[$];
    logic [31:0] fixed_w [2];

    task automatic prep_words();
        foreach (words_q[k]) begin
            for (int b = 0; b < 4; b++) tx_q.push_back(words_q[k][8*b +: 8]);
            exp_q.push_back({64'(k) << 2, words_q[k]});
        end
        wen_cnt = 0;
        ren_cnt = 0;
        done_cnt = 0;
        cpu_seen = 1'b0;
    endtask

    task automatic issue_start(input int n);
        @(negedge clk);
        num_words = (IDX_W+1)'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int k = 0; k < n; k++) words_q.push_back($urandom);
    endtask

    task automatic run_load(input bit exp_ok, output int cycles);
        int n;
        int limit;
        n = words_q.size();
        prep_words();
        issue_start(n);
        check1("start_clears_error", error, 1'b0);
        check1("busy_after_start", busy, 1'b1);
        cycles = 1;
        limit = 7 * n + 20;
        while (!cpu_enable && !error && cycles < limit) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (cycles >= limit) fail_now("load_completion");
        check1("done_on_entry", done, exp_ok);
        check1("cpu_enable_on_entry", cpu_enable, exp_ok);
        check1("error_at_end", error, !exp_ok);
        @(posedge clk);
        #1;
        check1("done_one_cycle", done, 1'b0);
        check1("cpu_enable_held", cpu_enable, exp_ok);
        check1("busy_cleared", busy, 1'b0);
        check("done_count", 64'(done_cnt), 64'(exp_ok));
        check("write_count", 64'(wen_cnt), 64'(n));
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic run_bad(input int n);
        int w0;
        w0 = wen_cnt;
        issue_start(n);
        check1("bad_count_error", error, 1'b1);
        check1("bad_count_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("bad_count_no_write", 64'(wen_cnt), 64'(w0));
        check1("bad_count_error_sticky", error, 1'b1);
        check1("bad_count_stays_idle", busy, 1'b0);
    endtask

    task automatic do_halt(input bit with_start);
        if (with_start) begin
            issue_start(1);
            check1("run_start_ignored_busy", busy, 1'b0);
            check1("run_start_ignored_cpu", cpu_enable, 1'b1);
        end
        @(negedge clk);
        halt = 1'b1;
        @(posedge clk);
        #1;
        halt = 1'b0;
        check1("halt_cpu_off", cpu_enable, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check1("halt_idle_busy", busy, 1'b0);
        check1("halt_idle_cpu", cpu_enable, 1'b0);
    endtask

    typedef struct {
        int nw;
        bit fixed;
        bit bub;
        bit exp_err;
        bit chk_cyc;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int cyc;
        int lim;
        fixed_w[0] = 32'h0000_0013;
        fixed_w[1] = 32'h0010_0093;
        vecs[0] = '{nw: 2,   fixed: 1'b1, bub: 1'b0, exp_err: 1'b0, chk_cyc: 1'b1};
        vecs[1] = '{nw: 0,   fixed: 1'b0, bub: 1'b0, exp_err: 1'b1, chk_cyc: 1'b0};
        vecs[2] = '{nw: 1,   fixed: 1'b1, bub: 1'b1, exp_err: 1'b0, chk_cyc: 1'b0};
        vecs[3] = '{nw: 3,   fixed: 1'b0, bub: 1'b0, exp_err: 1'b0, chk_cyc: 1'b1};
        vecs[4] = '{nw: 513, fixed: 1'b0, bub: 1'b0, exp_err: 1'b1, chk_cyc: 1'b0};
        vecs[5] = '{nw: 512, fixed: 1'b0, bub: 1'b0, exp_err: 1'b0, chk_cyc: 1'b1};
        vecs[6] = '{nw: 4,   fixed: 1'b0, bub: 1'b1, exp_err: 1'b0, chk_cyc: 1'b0};

        #1;
        check("reset_flags", 64'({in_ready, wen_ext, ren_ext, cpu_enable, busy, done, error}), 64'h0);
        check("reset_addr", addr_ext, 64'h0);
        check("reset_wdata", 64'(wdata_ext), 64'h0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_err) begin
                run_bad(vecs[i].nw);
            end else begin
                words_q.delete();
                for (int k = 0; k < vecs[i].nw; k++)
                    words_q.push_back(vecs[i].fixed ? fixed_w[k] : $urandom);
                bubble = vecs[i].bub;
                run_load(1'b1, cyc);
                if (vecs[i].chk_cyc)
                    check("start_to_run_cycles", 64'(cyc), 64'(5 * vecs[i].nw + 1 + 2 * vecs[i].nw * VERIFY));
                do_halt(i == 0);
            end
        end
        bubble = 1'b0;

        // Reset during the third write of an 8-word load, then reload from index 0
        rand_words(8);
        prep_words();
        issue_start(8);
        lim = 0;
        while (!(wen_ext && wen_cnt == 3) && lim < 100) begin
            @(negedge clk);
            #2;
            lim++;
        end
        if (lim >= 100) fail_now("third_write_wait");
        arst_n = 1'b0;
        #1;
        check1("async_rst_wen", wen_ext, 1'b0);
        check1("async_rst_busy", busy, 1'b0);
        check1("async_rst_cpu", cpu_enable, 1'b0);
        check1("async_rst_in_ready", in_ready, 1'b0);
        check("async_rst_addr", addr_ext, 64'h0);
        check("async_rst_wdata", 64'(wdata_ext), 64'h0);
        tx_q.delete();
        exp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        rand_words(2);
        run_load(1'b1, cyc);

        // Reset while running drops the CPU enable without a clock edge
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check1("run_rst_cpu", cpu_enable, 1'b0);
        check1("run_rst_error", error, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;

`ifdef PROG_LOADER_VERIFY_EN
        corrupt1 = 1'b1;
        rand_words(2);
        run_load(1'b0, cyc);
        check("verify_bad_reads", 64'(ren_cnt), 64'd2);
        check1("verify_bad_no_cpu", cpu_seen, 1'b0);
        corrupt1 = 1'b0;
        rand_words(2);
        run_load(1'b1, cyc);
        check("verify_good_reads", 64'(ren_cnt), 64'd2);
        do_halt(1'b0);
`else
        check("no_verify_reads", 64'(ren_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter IDX_W, default 9: word-index width; capacity 2^IDX_W 32-bit words.
REQ-002 clk  input  1  main clock; all state changes on its rising edge.
REQ-003 arst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  load request; sampled in IDLE only.
REQ-005 num_words  input  IDX_W+1  number of words to load, sampled with accepted start.
REQ-006 halt  input  1  stops the running CPU; sampled in RUN only.
REQ-007 in_valid  input  1  host byte valid.
REQ-008 in_byte  input  8  host program byte, little-endian within a word.
REQ-009 in_ready  output  1  loader accepts in_byte this cycle.
REQ-010 addr_ext  output  64  instruction-memory byte address, {zeros, word_idx, 2'b00}.
REQ-011 wen_ext  output  1  instruction-memory write strobe.
REQ-012 ren_ext  output  1  instruction-memory read strobe.
REQ-013 wdata_ext  output  32  instruction word to write.
REQ-014 rdata_ext  input  32  instruction-memory read data, valid the cycle after ren_ext.
REQ-015 cpu_enable  output  1  drives the CPU enable input.
REQ-016 busy / done / error  output  1 each  load in progress / 1-cycle pulse on load success / sticky failure flag.

Function
REQ-017 States: IDLE, COLLECT, WRITE, VRD, VCHK, RUN.
REQ-018 IDLE: start=1 with 1<=num_words<=2^IDX_W -> COLLECT, word_idx=0, byte_cnt=0, sum=0, error cleared.
REQ-019 IDLE: start=1 with num_words=0 or >2^IDX_W -> error=1, stay IDLE.
REQ-020 COLLECT: in_ready=1; each in_valid&in_ready handshake stores in_byte at bits [8*byte_cnt+7:8*byte_cnt]; after the 4th byte -> WRITE.
REQ-021 WRITE: one cycle, wen_ext=1, in_ready=0, addr_ext per word_idx, wdata_ext=assembled word; sum+=word (mod 2^32).
REQ-022 After WRITE: word_idx+1 < num_words -> COLLECT with word_idx+1; otherwise -> verify (REQ-032) or RUN.
REQ-023 Sustained in_valid=1 yields exactly 5 cycles per word; bubbles on in_valid only stall COLLECT.
REQ-024 wen_ext and ren_ext never both 1; both 0 outside WRITE/VRD.
REQ-025 Entry to RUN: done=1 for one cycle; cpu_enable=1 from that cycle while in RUN.
REQ-026 RUN: halt=1 -> IDLE, cpu_enable=0 next cycle; start ignored in RUN.
REQ-027 busy=1 in COLLECT, WRITE, VRD, VCHK; start ignored while busy.
REQ-028 word_idx never wraps: the final word index is num_words-1, max 2^IDX_W-1.
REQ-029 Outputs not strobed hold 0 (addr_ext, wdata_ext drive 0 outside their active states).

Reset
REQ-030 arst_n=0 at any time, including mid-load or RUN: state=IDLE, all outputs 0, counters and sum cleared, immediately and without waiting for clk.
REQ-031 A partially loaded memory after reset is not reported; the next start reloads from index 0.

Configuration
REQ-032 Macro PROG_LOADER_VERIFY_EN defined: after the last WRITE -> VRD with word_idx=0, rsum=0; VRD asserts ren_ext for word_idx (1 cycle); VCHK adds rdata_ext to rsum, increments word_idx, returns to VRD until num_words words are read; then rsum==sum -> RUN, else error=1, -> IDLE, cpu_enable stays 0.
REQ-033 Macro undefined: VRD/VCHK and rsum absent; ren_ext tied 0; last WRITE -> RUN directly.

Verification
REQ-034 Reset, then num_words=2, bytes 13 00 00 00 93 00 10 00 streamed continuously -> writes 0x00000013 @0x0 and 0x00100093 @0x4; done 1 cycle; cpu_enable=1 (11 cycles after start without verify).
REQ-035 start with num_words=0 -> error=1, no wen_ext, state IDLE; following valid start clears error.
REQ-036 in_valid toggled every other cycle for 1 word -> in_ready only in COLLECT; single write, same data as continuous case.
REQ-037 arst_n pulsed low after the 3rd word of 8 -> wen_ext, cpu_enable, busy drop to 0 asynchronously; restart writes from addr 0x0.
REQ-038 With PROG_LOADER_VERIFY_EN, memory model corrupts word 1 on read -> 2 ren_ext strobes, error=1, cpu_enable never asserted; uncorrupted -> done and RUN.
REQ-039 RUN then halt=1 -> cpu_enable=0 next cycle, IDLE; start during RUN ignored.
